// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS execute stage:
//   - ALUOp codes driven by the main decoder in ID
//   - R-type funct codes recognised by the ALU control decode
//   - alu_op_e : internal ALU operation after ALU control decode
//   - mult_state_e : iterative multiplier FSM states
//   - ex_mem_t : EX/MEM pipeline register bundle
//   - mag32() : two's-complement magnitude helper for signed multiply
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int MULT_STEPS = 32;

  // ALUOp from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct field
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_MFHI,
    ALU_MFLO,
    ALU_MULT,
    ALU_MULTU,
    ALU_ILLEGAL
  } alu_op_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_BUSY,
    MS_DONE
  } mult_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic [31:0] branch_target;
    logic        zero;
    logic [4:0]  wreg;
  } ex_mem_t;

  // Magnitude of v when treated as signed; raw value otherwise.
  // -2^31 maps to 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_unit.sv
// -----------------------------------------------------------------------------
// mult_unit
// Iterative 32x32 -> 64 shift-add multiplier owning the HI/LO registers.
// One add step per cycle; sign handled by multiplying magnitudes and negating
// the final product.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : a mult/multu is in EX and not being flushed
//   signed_i        : 1 = mult (signed), 0 = multu
//   a_i, b_i        : operands
//   hi_o, lo_o      : architectural HI/LO
//   stall_o         : front end must hold (combinational)
// -----------------------------------------------------------------------------
module mult_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_o
);

  mult_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        last_step;
  logic [63:0] sum;

  assign last_step = (cnt_q == 5'(MULT_STEPS - 1));
  assign sum       = acc_q + (mplr_q[0] ? mcand_q : 64'd0);

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MS_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first, otherwise a path that
  // skips the assignment infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: if (start_i)   state_d = MS_BUSY;
      MS_BUSY: if (last_step) state_d = MS_DONE;
      // DONE lets the still-held mult leave EX without being restarted.
      MS_DONE:                state_d = MS_IDLE;
      default:                state_d = MS_IDLE;
    endcase
  end

  // Output logic: IDLE stalls in the same cycle the mult is seen, then BUSY
  // stalls for every step, giving 1 + MULT_STEPS cycles of front-end hold.
  always_comb begin
    stall_o = !rst && (((state_q == MS_IDLE) && start_i) || (state_q == MS_BUSY));
  end

  // Datapath next-state
  always_comb begin
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MS_IDLE: begin
        if (start_i) begin
          mcand_d = {32'd0, mag32(a_i, signed_i)};
          mplr_d  = mag32(b_i, signed_i);
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          neg_d   = signed_i && (a_i[31] ^ b_i[31]);
        end
      end
      MS_BUSY: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 5'd1;
        if (last_step) begin
          {hi_d, lo_d} = neg_q ? (~sum + 64'd1) : sum;
        end
      end
      default: ;
    endcase
  end

  // NOTE: HI/LO are architectural and software-visible, so they take a reset
  // value; an aborted multiply therefore leaves them at 0, not stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 5'd0;
      mcand_q <= 64'd0;
      mplr_q  <= 32'd0;
      acc_q   <= 64'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage MIPS pipeline: ALU control decode, operand
// muxing, ALU, branch target, destination select, iterative HI/LO multiplier,
// and the EX/MEM pipeline register.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   flush                 : squash the instruction currently in EX
//   EX_*                  : control and datapath from the ID/EX register
//   MEM_*                 : registered EX/MEM outputs
//   stall                 : combinational; PC, IF/ID, ID/EX hold while 1
// Parameter:
//   MULT_ENABLE           : 0 decodes mult/multu as illegal
// -----------------------------------------------------------------------------
module ex_stage
  import mips_pkg::*;
#(
  parameter int MULT_ENABLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        EX_RegDst,
  input  logic        EX_RegWrite,
  input  logic        EX_Branch,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic        EX_ALUSrc,
  input  logic        EX_MemtoReg,
  input  logic [1:0]  EX_ALUOp,
  input  logic [31:0] EX_pc_plus_4,
  input  logic [31:0] EX_rdata1,
  input  logic [31:0] EX_rdata2,
  input  logic [31:0] EX_const_or_addr,
  input  logic [4:0]  EX_rt,
  input  logic [4:0]  EX_rd,
  output logic        MEM_RegWrite,
  output logic        MEM_Branch,
  output logic        MEM_MemRead,
  output logic        MEM_MemWrite,
  output logic        MEM_MemtoReg,
  output logic [31:0] MEM_alu_result,
  output logic [31:0] MEM_wdata,
  output logic [31:0] MEM_branch_target,
  output logic        MEM_zero,
  output logic [4:0]  MEM_wreg,
  output logic        stall
);

  alu_op_e     alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b, diff, alu_result;
  logic [31:0] branch_target;
  logic [4:0]  wreg;
  logic        is_mult, reg_write_eff;
  logic [31:0] hi, lo;
  ex_mem_t     mem_d, mem_q;

  assign funct = EX_const_or_addr[5:0];

  // ALU control decode
  always_comb begin
    alu_op = ALU_ILLEGAL;
    case (EX_ALUOp)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      ALUOP_OR:  alu_op = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: alu_op = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_op = ALU_SUB;
          FUNCT_AND:             alu_op = ALU_AND;
          FUNCT_OR:              alu_op = ALU_OR;
          FUNCT_XOR:             alu_op = ALU_XOR;
          FUNCT_NOR:             alu_op = ALU_NOR;
          FUNCT_SLT:             alu_op = ALU_SLT;
          FUNCT_SLTU:            alu_op = ALU_SLTU;
          FUNCT_MFHI:            alu_op = ALU_MFHI;
          FUNCT_MFLO:            alu_op = ALU_MFLO;
          FUNCT_MULT:            alu_op = (MULT_ENABLE != 0) ? ALU_MULT  : ALU_ILLEGAL;
          FUNCT_MULTU:           alu_op = (MULT_ENABLE != 0) ? ALU_MULTU : ALU_ILLEGAL;
          default:               alu_op = ALU_ILLEGAL;
        endcase
      end
    endcase
  end

  // Operands, branch target and destination
  assign op_a          = EX_rdata1;
  assign op_b          = EX_ALUSrc ? EX_const_or_addr : EX_rdata2;
  assign diff          = op_a - op_b;
  assign branch_target = EX_pc_plus_4 + {EX_const_or_addr[29:0], 2'b00};
  assign wreg          = EX_RegDst ? EX_rd : EX_rt;

  assign is_mult       = (alu_op == ALU_MULT) || (alu_op == ALU_MULTU);
  // Illegal ops and multiplies never write the register file.
  assign reg_write_eff = EX_RegWrite && !is_mult && (alu_op != ALU_ILLEGAL);

  // ALU
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = diff;
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_NOR:  alu_result = ~(op_a | op_b);
      ALU_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {31'd0, op_a < op_b};
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = 32'd0;
    endcase
  end

  // A flushed mult must not start; once BUSY the unit ignores start_i,
  // so a later flush cannot abort it.
  mult_unit u_mult (
    .clk      (clk),
    .rst      (rst),
    .start_i  (is_mult && !flush),
    .signed_i (alu_op == ALU_MULT),
    .a_i      (op_a),
    .b_i      (op_b),
    .hi_o     (hi),
    .lo_o     (lo),
    .stall_o  (stall)
  );

  // EX/MEM next value: a bubble while stalled, control squashed on flush.
  always_comb begin
    mem_d = '0;
    if (!stall) begin
      mem_d.alu_result    = alu_result;
      mem_d.wdata         = EX_rdata2;
      mem_d.branch_target = branch_target;
      mem_d.zero          = (diff == 32'd0);
      mem_d.wreg          = wreg;
      if (!flush) begin
        mem_d.reg_write  = reg_write_eff;
        mem_d.branch     = EX_Branch;
        mem_d.mem_read   = EX_MemRead;
        mem_d.mem_write  = EX_MemWrite;
        mem_d.mem_to_reg = EX_MemtoReg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign MEM_RegWrite      = mem_q.reg_write;
  assign MEM_Branch        = mem_q.branch;
  assign MEM_MemRead       = mem_q.mem_read;
  assign MEM_MemWrite      = mem_q.mem_write;
  assign MEM_MemtoReg      = mem_q.mem_to_reg;
  assign MEM_alu_result    = mem_q.alu_result;
  assign MEM_wdata         = mem_q.wdata;
  assign MEM_branch_target = mem_q.branch_target;
  assign MEM_zero          = mem_q.zero;
  assign MEM_wreg          = mem_q.wreg;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
// Directed self-checking bench for ex_stage with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        EX_RegDst, EX_RegWrite, EX_Branch, EX_MemRead, EX_MemWrite;
  logic        EX_ALUSrc, EX_MemtoReg;
  logic [1:0]  EX_ALUOp;
  logic [31:0] EX_pc_plus_4, EX_rdata1, EX_rdata2, EX_const_or_addr;
  logic [4:0]  EX_rt, EX_rd;
  logic        MEM_RegWrite, MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg;
  logic [31:0] MEM_alu_result, MEM_wdata, MEM_branch_target;
  logic        MEM_zero;
  logic [4:0]  MEM_wreg;
  logic        stall;

  int checks   = 0;
  int failures = 0;
  int n_stall;

  ex_stage #(.MULT_ENABLE(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .EX_RegDst         (EX_RegDst),
    .EX_RegWrite       (EX_RegWrite),
    .EX_Branch         (EX_Branch),
    .EX_MemRead        (EX_MemRead),
    .EX_MemWrite       (EX_MemWrite),
    .EX_ALUSrc         (EX_ALUSrc),
    .EX_MemtoReg       (EX_MemtoReg),
    .EX_ALUOp          (EX_ALUOp),
    .EX_pc_plus_4      (EX_pc_plus_4),
    .EX_rdata1         (EX_rdata1),
    .EX_rdata2         (EX_rdata2),
    .EX_const_or_addr  (EX_const_or_addr),
    .EX_rt             (EX_rt),
    .EX_rd             (EX_rd),
    .MEM_RegWrite      (MEM_RegWrite),
    .MEM_Branch        (MEM_Branch),
    .MEM_MemRead       (MEM_MemRead),
    .MEM_MemWrite      (MEM_MemWrite),
    .MEM_MemtoReg      (MEM_MemtoReg),
    .MEM_alu_result    (MEM_alu_result),
    .MEM_wdata         (MEM_wdata),
    .MEM_branch_target (MEM_branch_target),
    .MEM_zero          (MEM_zero),
    .MEM_wreg          (MEM_wreg),
    .stall             (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush            = 1'b0;
    EX_RegDst        = 1'b0;
    EX_RegWrite      = 1'b0;
    EX_Branch        = 1'b0;
    EX_MemRead       = 1'b0;
    EX_MemWrite      = 1'b0;
    EX_ALUSrc        = 1'b0;
    EX_MemtoReg      = 1'b0;
    EX_ALUOp         = 2'b00;
    EX_pc_plus_4     = 32'd0;
    EX_rdata1        = 32'd0;
    EX_rdata2        = 32'd0;
    EX_const_or_addr = 32'd0;
    EX_rt            = 5'd0;
    EX_rd            = 5'd0;
  endtask

  task automatic rtype(input logic [5:0] funct, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    clear_inputs();
    EX_ALUOp         = 2'b10;
    EX_RegDst        = 1'b1;
    EX_RegWrite      = 1'b1;
    EX_const_or_addr = {26'd0, funct};
    EX_rdata1        = a;
    EX_rdata2        = b;
    EX_rd            = rd;
    EX_rt            = 5'd9;
  endtask

  // Counts cycles with stall high, bounded so a stuck stall cannot hang.
  task automatic count_stall(output int n);
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {MEM_RegWrite, MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_zero}, 0);
    check("rst_data", {MEM_alu_result, MEM_wdata}, 0);
    check("rst_target_wreg", {MEM_branch_target, 27'd0, MEM_wreg}, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;

    // add 5 + 7 -> rd 3
    rtype(6'h20, 32'd5, 32'd7, 5'd3);
    #1 check("add_stall", stall, 0);
    tick();
    check("add_result", MEM_alu_result, 12);
    check("add_wreg", MEM_wreg, 3);
    check("add_regwrite", MEM_RegWrite, 1);
    check("add_wdata", MEM_wdata, 7);

    // beq with A=B, offset -1 -> target 0x100 - 4
    clear_inputs();
    EX_ALUOp = 2'b01; EX_Branch = 1'b1;
    EX_rdata1 = 32'd9; EX_rdata2 = 32'd9;
    EX_pc_plus_4 = 32'h100; EX_const_or_addr = 32'hFFFF_FFFF;
    tick();
    check("beq_target", MEM_branch_target, 32'hFC);
    check("beq_zero", MEM_zero, 1);
    check("beq_branch", MEM_Branch, 1);
    check("beq_regwrite", MEM_RegWrite, 0);

    // signed vs unsigned compare of -1 and 1
    rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd4);
    tick();
    check("slt_result", MEM_alu_result, 1);
    check("slt_zero", MEM_zero, 0);
    rtype(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd4);
    tick();
    check("sltu_result", MEM_alu_result, 0);

    // ori: ALUOp=11, immediate operand, dest = rt
    clear_inputs();
    EX_ALUOp = 2'b11; EX_ALUSrc = 1'b1; EX_RegWrite = 1'b1;
    EX_rdata1 = 32'hF0; EX_rdata2 = 32'h1234; EX_const_or_addr = 32'h0F;
    EX_rt = 5'd4; EX_rd = 5'd7;
    tick();
    check("ori_result", MEM_alu_result, 32'hFF);
    check("ori_wreg", MEM_wreg, 4);

    // unknown funct -> result 0, no write
    rtype(6'h3F, 32'd5, 32'd7, 5'd3);
    tick();
    check("illegal_result", MEM_alu_result, 0);
    check("illegal_regwrite", MEM_RegWrite, 0);

    // mult -3 * 7 = -21
    rtype(6'h18, 32'hFFFF_FFFD, 32'd7, 5'd5);
    #1 count_stall(n_stall);
    check("mult_stall_cycles", n_stall, 33);
    tick();  // DONE edge: held mult leaves as a bubble
    check("mult_bubble_regwrite", MEM_RegWrite, 0);
    rtype(6'h12, 32'd0, 32'd0, 5'd8);
    tick();
    check("mult_mflo", MEM_alu_result, 32'hFFFF_FFEB);
    check("mflo_regwrite", MEM_RegWrite, 1);
    rtype(6'h10, 32'd0, 32'd0, 5'd8);
    tick();
    check("mult_mfhi", MEM_alu_result, 32'hFFFF_FFFF);

    // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    rtype(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd5);
    #1 count_stall(n_stall);
    check("multu_stall_cycles", n_stall, 33);
    tick();
    rtype(6'h10, 32'd0, 32'd0, 5'd8);
    tick();
    check("multu_mfhi", MEM_alu_result, 1);
    rtype(6'h12, 32'd0, 32'd0, 5'd8);
    tick();
    check("multu_mflo", MEM_alu_result, 32'hFFFF_FFFE);

    // lw without and with flush
    clear_inputs();
    EX_ALUOp = 2'b00; EX_ALUSrc = 1'b1; EX_MemRead = 1'b1;
    EX_RegWrite = 1'b1; EX_MemtoReg = 1'b1;
    EX_rdata1 = 32'h1000; EX_const_or_addr = 32'h24; EX_rt = 5'd6;
    tick();
    check("lw_addr", MEM_alu_result, 32'h1024);
    check("lw_memread", MEM_MemRead, 1);
    flush = 1'b1;
    tick();
    check("lw_flush_ctrl", {MEM_MemRead, MEM_RegWrite, MEM_MemtoReg}, 0);

    // flushed mult in IDLE does not start
    rtype(6'h18, 32'd5, 32'd5, 5'd5);
    flush = 1'b1;
    #1 check("flush_mult_stall", stall, 0);
    tick();
    check("flush_mult_stall_after", stall, 0);
    rtype(6'h12, 32'd0, 32'd0, 5'd8);
    tick();
    check("flush_mult_lo_kept", MEM_alu_result, 32'hFFFF_FFFE);

    // reset at BUSY step 10 aborts the multiply
    rtype(6'h18, 32'hFFFF_FFFD, 32'd7, 5'd5);
    tick();                 // IDLE -> BUSY, counter 0
    repeat (10) tick();     // counter 10
    check("busy_stall", stall, 1);
    rst = 1'b1;
    #1;
    check("rstbusy_stall", stall, 0);
    check("rstbusy_ctrl", {MEM_RegWrite, MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_zero}, 0);
    check("rstbusy_data", {MEM_alu_result, MEM_branch_target}, 0);
    rtype(6'h10, 32'd0, 32'd0, 5'd8);
    tick();
    rst = 1'b0;
    tick();
    check("rstbusy_hi_cleared", MEM_alu_result, 0);
    rtype(6'h12, 32'd0, 32'd0, 5'd8);
    tick();
    check("rstbusy_lo_cleared", MEM_alu_result, 0);
    rtype(6'h18, 32'hFFFF_FFFD, 32'd7, 5'd5);
    #1 count_stall(n_stall);
    check("rerun_stall_cycles", n_stall, 33);
    tick();
    rtype(6'h12, 32'd0, 32'd0, 5'd8);
    tick();
    check("rerun_mflo", MEM_alu_result, 32'hFFFF_FFEB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
